// File: rtl/instruction_encoder.sv
// Two-stage pipelined RV32 instruction encoder: stage 0 captures the field set and
// branch offset, stage 1 packs/range-checks it and emits the word at a running address.
package instruction_encoder_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned FMT_W = 3;
    localparam int unsigned OPC_W = 7;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned F7_W  = 7;
    localparam int unsigned REG_W = 5;

    localparam logic [FMT_W-1:0] FMT_R  = 3'd0;
    localparam logic [FMT_W-1:0] FMT_I  = 3'd1;
    localparam logic [FMT_W-1:0] FMT_S  = 3'd2;
    localparam logic [FMT_W-1:0] FMT_SB = 3'd3;
    localparam logic [FMT_W-1:0] FMT_U  = 3'd4;
    localparam logic [FMT_W-1:0] FMT_UJ = 3'd5;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] ADDR_STEP = 32'd4;

    // Stage-0 payload: captured fields plus the precomputed PC-relative offset
    typedef struct packed {
        logic [FMT_W-1:0] fmt;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  off;
    } s0_t;
endpackage

module instruction_encoder
    import instruction_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FMT_W-1:0] fmt,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic [F7_W-1:0]  funct7,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  program_counter,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  instr,
    output logic [XLEN-1:0]  instr_addr,
    output logic             err
);

    s0_t             s0;
    logic            s0_valid;
    logic            s1_adv;
    logic            in_fire;
    logic            out_fire;

    logic            i_ok;
    logic            sb_ok;
    logic            u_ok;
    logic            uj_ok;
    logic            legal;
    logic [XLEN-1:0] packed_word;
    logic [XLEN-1:0] enc_instr;
    logic            enc_err;

    // Handshake control; rst_n gating keeps in_ready low throughout reset
    assign s1_adv   = ~out_valid | out_ready;
    assign in_ready = rst_n & (~s0_valid | s1_adv);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Stage 0: capture request and offset (imm - pc, modulo 2^32)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0       <= '0;
        end else if (in_fire) begin
            s0_valid   <= 1'b1;
            s0.fmt     <= fmt;
            s0.opcode  <= opcode;
            s0.funct3  <= funct3;
            s0.funct7  <= funct7;
            s0.rd      <= rd;
            s0.rs1     <= rs1;
            s0.rs2     <= rs2;
            s0.imm     <= imm;
            s0.off     <= XLEN'(imm - program_counter);
        end else if (s1_adv) begin
            s0_valid <= 1'b0;
        end
    end

    // Range checks: sign-extension redundancy of the upper bits, and alignment
    assign i_ok  = (&s0.imm[XLEN-1:11]) | ~(|s0.imm[XLEN-1:11]);
    assign sb_ok = ((&s0.off[XLEN-1:12]) | ~(|s0.off[XLEN-1:12])) & ~s0.off[0];
    assign u_ok  = ~(|s0.imm[11:0]);
    assign uj_ok = ((&s0.off[XLEN-1:20]) | ~(|s0.off[XLEN-1:20])) & ~s0.off[0];

    // Field packing per format; anything unencodable becomes a flagged NOP
    always_comb begin
        packed_word = '0;
        legal       = 1'b0;
        enc_instr   = NOP_INSTR;
        enc_err     = 1'b1;
        case (s0.fmt)
            FMT_R: begin
                packed_word = {s0.funct7, s0.rs2, s0.rs1, s0.funct3, s0.rd, s0.opcode};
                legal       = 1'b1;
            end
            FMT_I: begin
                packed_word = {s0.imm[11:0], s0.rs1, s0.funct3, s0.rd, s0.opcode};
                legal       = i_ok;
            end
            FMT_S: begin
                packed_word = {s0.imm[11:5], s0.rs2, s0.rs1, s0.funct3,
                               s0.imm[4:0], s0.opcode};
                legal       = i_ok;
            end
            FMT_SB: begin
                packed_word = {s0.off[12], s0.off[10:5], s0.rs2, s0.rs1, s0.funct3,
                               s0.off[4:1], s0.off[11], s0.opcode};
                legal       = sb_ok;
            end
            FMT_U: begin
                packed_word = {s0.imm[XLEN-1:12], s0.rd, s0.opcode};
                legal       = u_ok;
            end
            FMT_UJ: begin
                packed_word = {s0.off[20], s0.off[10:1], s0.off[11], s0.off[19:12],
                               s0.rd, s0.opcode};
                legal       = uj_ok;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            enc_instr = packed_word;
            enc_err   = 1'b0;
        end
    end

    // Stage 1: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= '0;
            err       <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s0_valid;
            if (s0_valid) begin
                instr <= enc_instr;
                err   <= enc_err;
            end
        end
    end

    // Address counter advances on each output handshake, wrapping silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_addr <= '0;
        end else if (out_fire) begin
            instr_addr <= XLEN'(instr_addr + ADDR_STEP);
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed vector table, randomized
// traffic against a signed-range reference model, backpressure and reset sequences.
module tb_instruction_encoder;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } req_t;

    typedef struct packed {
        req_t        r;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } exp_t;

    localparam int NV = 12;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        err;
    req_t        cur;

    exp_t        exp_q[$];
    logic [31:0] addr_log[$];
    logic [31:0] exp_addr;
    int          n_checks;
    int          n_fail;
    int          n_acc;
    vec_t        vecs[NV];
    req_t        idle;
    req_t        ra;
    req_t        rb;
    req_t        rc;

    instruction_encoder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .fmt             (cur.fmt),
        .opcode          (cur.opcode),
        .funct3          (cur.funct3),
        .funct7          (cur.funct7),
        .rd              (cur.rd),
        .rs1             (cur.rs1),
        .rs2             (cur.rs2),
        .imm             (cur.imm),
        .program_counter (cur.pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .instr           (instr),
        .instr_addr      (instr_addr),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic req_t mkreq(input logic [2:0] f, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [31:0] im,
                                   input logic [31:0] p);
        req_t r;
        r.fmt = f; r.opcode = opc; r.funct3 = f3; r.funct7 = f7;
        r.rd = d; r.rs1 = s1; r.rs2 = s2; r.imm = im; r.pc = p;
        return r;
    endfunction

    // Reference: legality from signed value ranges, then the format's bit layout
    function automatic exp_t model(input req_t r);
        exp_t        e;
        logic [31:0] off;
        longint      si;
        longint      so;
        bit          ok;
        off = r.imm - r.pc;
        si  = longint'($signed(r.imm));
        so  = longint'($signed(off));
        ok  = 1'b0;
        e.instr = 32'h0;
        case (r.fmt)
            3'd0: begin ok = 1'b1; e.instr = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode}; end
            3'd1: begin
                ok = (si >= -2048) && (si <= 2047);
                e.instr = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            end
            3'd2: begin
                ok = (si >= -2048) && (si <= 2047);
                e.instr = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            end
            3'd3: begin
                ok = (so >= -4096) && (so <= 4095) && (so % 2 == 0);
                e.instr = {off[12], off[10:5], r.rs2, r.rs1, r.funct3, off[4:1], off[11], r.opcode};
            end
            3'd4: begin
                ok = (r.imm % 4096) == 0;
                e.instr = {r.imm[31:12], r.rd, r.opcode};
            end
            3'd5: begin
                ok = (so >= -(64'sd1 <<< 20)) && (so < (64'sd1 <<< 20)) && (so % 2 == 0);
                e.instr = {off[20], off[10:1], off[11], off[19:12], r.rd, r.opcode};
            end
            default: ok = 1'b0;
        endcase
        e.err = !ok;
        if (!ok) e.instr = 32'h0000_0013;
        return e;
    endfunction

    function automatic req_t rand_req();
        req_t        r;
        logic [31:0] t;
        r.fmt    = 3'($urandom_range(0, 7));
        r.opcode = 7'($urandom);
        r.funct3 = 3'($urandom);
        r.funct7 = 7'($urandom);
        r.rd     = 5'($urandom);
        r.rs1    = 5'($urandom);
        r.rs2    = 5'($urandom);
        r.pc     = 32'($urandom) & 32'hFFFF_FFFC;
        case ($urandom_range(0, 4))
            0: r.imm = 32'($urandom);
            1: r.imm = 32'(int'($urandom_range(0, 4200)) - 2100);
            2: r.imm = 32'(r.pc + 32'(int'($urandom_range(0, 8400)) - 4200));
            3: r.imm = 32'(r.pc + 32'(int'($urandom_range(0, 2200000)) - 1100000));
            default: begin t = 32'($urandom); r.imm = t & 32'hFFFF_F000; end
        endcase
        return r;
    endfunction

    // One clock: drive at the falling edge, score the settled outputs, then cross posedge
    task automatic tick(input logic iv, input req_t r, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        cur       = r;
        out_ready = ordy;
        #1;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check("sb_instr", instr, e.instr);
                check("sb_err", 32'(err), 32'(e.err));
                check("sb_addr", instr_addr, exp_addr);
                if (out_ready) begin
                    addr_log.push_back(instr_addr);
                    void'(exp_q.pop_front());
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
        if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(model(r));
            n_acc++;
        end
        @(posedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && exp_q.size() > 0; k++) tick(1'b0, idle, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        tick(1'b0, idle, 1'b1);
    endtask

    // Asynchronous reset mid-cycle, then release and confirm readiness
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_addr", instr_addr, 32'd0);
        exp_q.delete();
        addr_log.delete();
        exp_addr = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_acc = 0;
        exp_addr = 32'd0;
        idle     = '0;
        cur      = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = '{r: mkreq(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0),   instr: 32'hFFF0_0093, err: 1'b0};
        vecs[1]  = '{r: mkreq(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0108, 32'h100), instr: 32'h0020_8463, err: 1'b0};
        vecs[2]  = '{r: mkreq(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_00FC, 32'h100), instr: 32'hFFDF_F0EF, err: 1'b0};
        vecs[3]  = '{r: mkreq(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0),   instr: 32'h0000_0013, err: 1'b1};
        vecs[4]  = '{r: mkreq(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0,         32'h0),   instr: 32'h0000_0013, err: 1'b1};
        vecs[5]  = '{r: mkreq(3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 32'h0),   instr: 32'h4031_00B3, err: 1'b0};
        vecs[6]  = '{r: mkreq(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0),   instr: 32'h0020_A423, err: 1'b0};
        vecs[7]  = '{r: mkreq(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h0),   instr: 32'h1234_52B7, err: 1'b0};
        vecs[8]  = '{r: mkreq(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0),   instr: 32'h0000_0013, err: 1'b1};
        vecs[9]  = '{r: mkreq(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h0000_0105, 32'h100), instr: 32'h0000_0013, err: 1'b1};
        vecs[10] = '{r: mkreq(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0,         32'h0),   instr: 32'h0000_0013, err: 1'b1};
        vecs[11] = '{r: mkreq(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h0),   instr: 32'h8000_0093, err: 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd0);
        check("init_instr", instr, 32'd0);
        check("init_err", 32'(err), 32'd0);
        check("init_addr", instr_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_in_ready", 32'(in_ready), 32'd1);

        // Directed table: exact two-cycle latency, value, error flag and address
        for (int i = 0; i < NV; i++) begin
            tick(1'b1, vecs[i].r, 1'b1);
            #1;
            check("lat1_out_valid", 32'(out_valid), 32'd0);
            tick(1'b0, idle, 1'b0);
            #1;
            check("lat2_out_valid", 32'(out_valid), 32'd1);
            check("vec_instr", instr, vecs[i].instr);
            check("vec_err", 32'(err), 32'(vecs[i].err));
            check("vec_addr", instr_addr, 32'(i * 4));
            tick(1'b0, idle, 1'b1);
        end

        // Random traffic with random backpressure
        for (int i = 0; i < 600; i++)
            tick(1'($urandom_range(0, 1)), rand_req(), 1'($urandom_range(0, 3) != 0));
        drain();

        // Full throughput: a new request every cycle with no stall
        n_acc = 0;
        for (int i = 0; i < 20; i++) tick(1'b1, rand_req(), 1'b1);
        check("throughput_accepts", 32'(n_acc), 32'd20);
        drain();

        // Backpressure: three offered while stalled, only two fit
        do_reset();
        ra = mkreq(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0);
        rb = mkreq(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd2, 32'd0);
        rc = mkreq(3'd1, 7'h13, 3'd0, 7'h00, 5'd3, 5'd0, 5'd0, 32'd3, 32'd0);
        n_acc = 0;
        tick(1'b1, ra, 1'b0);
        tick(1'b1, rb, 1'b0);
        tick(1'b1, rc, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        tick(1'b1, rc, 1'b0);
        check("bp_accepted", 32'(n_acc), 32'd2);
        for (int k = 0; k < 8 && n_acc < 3; k++) tick(1'b1, rc, 1'b1);
        drain();
        check("bp_accepted_total", 32'(n_acc), 32'd3);
        check("bp_out_count", 32'(addr_log.size()), 32'd3);
        if (addr_log.size() == 3) begin
            check("bp_addr0", addr_log[0], 32'd0);
            check("bp_addr1", addr_log[1], 32'd4);
            check("bp_addr2", addr_log[2], 32'd8);
        end

        // Reset with both stages full, then the counter restarts at zero
        tick(1'b1, ra, 1'b0);
        tick(1'b1, rb, 1'b0);
        #1;
        check("mid_full_out_valid", 32'(out_valid), 32'd1);
        do_reset();
        tick(1'b1, rc, 1'b1);
        tick(1'b0, idle, 1'b0);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd1);
        check("post_rst_addr", instr_addr, 32'd0);
        check("post_rst_instr", instr, 32'h0030_0193);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
